// File: rtl/md_seq_unit.sv
// md_seq_unit: multi-cycle sequencer for the RV32M multiply/divide group.
// One shared datapath iterates one bit per cycle: LSB-first shift-add for the
// multiplies, restoring subtraction for the divides. The CPU is held through
// Stall while an operation is in flight.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous reset, active-high
//   req        - M instruction present in execute, held high until done
//   ALUControl - operation select (ALU_MUL..ALU_REMU, ALU_NOP)
//   Op1, Op2   - rs1 / rs2 values, sampled only when a request is accepted
//   flush      - abort the current operation (trap/redirect)
//   busy       - sequencer not idle
//   done       - one-cycle pulse, Result valid
//   Stall      - req & ~done
//   Result     - last result, held until the next operation completes
module md_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             Stall,
    output logic [WIDTH-1:0] Result
);

    // Operation codes, mirroring CPU_Control_Codes.vh.
    localparam logic [5:0] ALU_NOP    = 6'h00;
    localparam logic [5:0] ALU_MUL    = 6'h20;
    localparam logic [5:0] ALU_MULH   = 6'h21;
    localparam logic [5:0] ALU_MULHSU = 6'h22;
    localparam logic [5:0] ALU_MULHU  = 6'h23;
    localparam logic [5:0] ALU_DIV    = 6'h24;
    localparam logic [5:0] ALU_DIVU   = 6'h25;
    localparam logic [5:0] ALU_REM    = 6'h26;
    localparam logic [5:0] ALU_REMU   = 6'h27;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_reg;
    logic [CW-1:0]    count_reg;
    logic [5:0]       op_reg;
    logic             mul_mode_reg;
    logic             neg_res_reg;
    logic [WIDTH-1:0] mag_reg;      // multiplicand (mul) or divisor (div)
    logic [WIDTH:0]   acc_reg;      // product high half (mul) or partial remainder (div)
    logic [WIDTH-1:0] lo_reg;       // multiplier/product low half, or dividend/quotient
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;

    // Acceptance decode: operand magnitudes, result sign and the special cases.
    logic             is_mul, op1_signed, op2_signed, known, is_rem;
    logic             neg1, neg2, neg_res, special;
    logic [WIDTH-1:0] mag1, mag2, special_val;

    always_comb begin
        is_mul     = 1'b0;
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        known      = 1'b1;
        case (ALUControl)
            ALU_MUL, ALU_MULHU: is_mul = 1'b1;
            ALU_MULH: begin
                is_mul     = 1'b1;
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            ALU_MULHSU: begin
                is_mul     = 1'b1;
                op1_signed = 1'b1;
            end
            ALU_DIV, ALU_REM: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            ALU_DIVU, ALU_REMU: known = 1'b1;
            default: known = 1'b0;
        endcase

        is_rem = (ALUControl == ALU_REM) || (ALUControl == ALU_REMU);
        neg1   = op1_signed & Op1[WIDTH-1];
        neg2   = op2_signed & Op2[WIDTH-1];
        // MIN_INT negates to itself, which read unsigned is exactly 2^(WIDTH-1).
        mag1   = neg1 ? (~Op1 + ONE) : Op1;
        mag2   = neg2 ? (~Op2 + ONE) : Op2;
        // Remainder follows the dividend sign; everything else is sign1 ^ sign2.
        neg_res = (ALUControl == ALU_REM) ? neg1 : (neg1 ^ neg2);

        special     = 1'b0;
        special_val = '0;
        if (!known) begin
            special = 1'b1;
        end else if (!is_mul && (Op2 == '0)) begin
            special     = 1'b1;
            special_val = is_rem ? Op1 : '1;
        end else if (op1_signed && !is_mul && (Op1 == MIN_INT) && (Op2 == '1)) begin
            special     = 1'b1;
            special_val = is_rem ? '0 : MIN_INT;
        end
    end

    // One iteration of the shared datapath.
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] lo_next;

    always_comb begin
        addend    = lo_reg[0] ? mag_reg : {WIDTH{1'b0}};
        mul_sum   = acc_reg + {1'b0, addend};
        rem_shift = {acc_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
        diff      = {1'b0, rem_shift} - {2'b00, mag_reg};
        if (mul_mode_reg) begin
            acc_next = {1'b0, mul_sum[WIDTH:1]};
            lo_next  = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else begin
            // Borrow out means the trial subtraction failed: keep the shifted remainder.
            acc_next = diff[WIDTH+1] ? rem_shift : diff[WIDTH:0];
            lo_next  = {lo_reg[WIDTH-2:0], ~diff[WIDTH+1]};
        end
    end

    // Sign correction and half select.
    logic [WIDTH-1:0] hi, hi_neg, rem_neg, quo_neg, fix_val;

    always_comb begin
        hi      = acc_reg[WIDTH-1:0];
        // High half of the negated 2*WIDTH product: the +1 only carries into
        // the high half when the low half is zero.
        hi_neg  = ~hi + {{(WIDTH-1){1'b0}}, (lo_reg == '0)};
        rem_neg = ~hi + ONE;
        quo_neg = ~lo_reg + ONE;
        case (op_reg)
            ALU_MUL:                         fix_val = lo_reg;
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_val = neg_res_reg ? hi_neg : hi;
            ALU_DIV, ALU_DIVU:               fix_val = neg_res_reg ? quo_neg : lo_reg;
            ALU_REM, ALU_REMU:               fix_val = neg_res_reg ? rem_neg : hi;
            default:                         fix_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            op_reg       <= ALU_NOP;
            mul_mode_reg <= 1'b0;
            neg_res_reg  <= 1'b0;
            mag_reg      <= '0;
            acc_reg      <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req && !flush) begin
                        op_reg       <= ALUControl;
                        mul_mode_reg <= is_mul;
                        neg_res_reg  <= neg_res;
                        mag_reg      <= is_mul ? mag1 : mag2;
                        lo_reg       <= is_mul ? mag2 : mag1;
                        acc_reg      <= '0;
                        count_reg    <= CNT_MAX;
                        if (special) begin
                            result_reg <= special_val;
                            done_reg   <= 1'b1;
                            state_reg  <= S_DONE;
                        end else begin
                            state_reg  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_reg <= S_IDLE;
                    end else begin
                        acc_reg   <= acc_next;
                        lo_reg    <= lo_next;
                        count_reg <= count_reg - CNT_ONE;
                        if (count_reg == '0) begin
                            state_reg <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state_reg <= S_IDLE;
                    end else begin
                        result_reg <= fix_val;
                        done_reg   <= 1'b1;
                        state_reg  <= S_DONE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = done_reg;
    assign Stall  = req & ~done_reg;
    assign Result = result_reg;

endmodule

// File: tb/tb_md_seq_unit.sv
// tb_md_seq_unit: self-checking bench for md_seq_unit.
// A transaction-level RV32M model (64-bit arithmetic, latency by rule) predicts
// busy/done/Stall/Result every cycle; directed vectors pin the model and the
// flush, drop-req, idle-flush and asynchronous-reset behaviour, then a
// randomised run exercises all operations and corner operands.
module tb_md_seq_unit;

    localparam logic [5:0] ALU_NOP    = 6'h00;
    localparam logic [5:0] ALU_MUL    = 6'h20;
    localparam logic [5:0] ALU_MULH   = 6'h21;
    localparam logic [5:0] ALU_MULHSU = 6'h22;
    localparam logic [5:0] ALU_MULHU  = 6'h23;
    localparam logic [5:0] ALU_DIV    = 6'h24;
    localparam logic [5:0] ALU_DIVU   = 6'h25;
    localparam logic [5:0] ALU_REM    = 6'h26;
    localparam logic [5:0] ALU_REMU   = 6'h27;
    localparam logic [31:0] MIN_INT   = 32'h80000000;

    logic        clk, rst, req, flush;
    logic [5:0]  ALUControl;
    logic [31:0] Op1, Op2, Result;
    logic        busy, done, Stall;

    int tests = 0;
    int fails = 0;

    md_seq_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req(req), .ALUControl(ALUControl),
        .Op1(Op1), .Op2(Op2), .flush(flush),
        .busy(busy), .done(done), .Stall(Stall), .Result(Result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference RV32M semantics.
    function automatic logic [31:0] ref_m(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            ALU_MUL:    begin p = ua * ub; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == MIN_INT && b == 32'hFFFFFFFF) return MIN_INT;
                p = sa / sb; return p[31:0];
            end
            ALU_DIVU: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            ALU_REM: begin
                if (b == 32'd0) return a;
                if (a == MIN_INT && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            ALU_REMU: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    // Operations that skip the iterative phase and finish one cycle after accept.
    function automatic bit is_special(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: return 1'b0;
            ALU_DIV, ALU_REM: return (b == 32'd0) || (a == MIN_INT && b == 32'hFFFFFFFF);
            ALU_DIVU, ALU_REMU: return (b == 32'd0);
            default: return 1'b1;
        endcase
    endfunction

    // Transaction model: accepted op completes after 1 or 34 cycles, unless flushed.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_result = 32'd0;
    logic [31:0] m_pending = 32'd0;
    logic [5:0]  m_op = 6'd0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_left   <= 0;
            m_result <= 32'd0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (flush) begin
                m_busy <= 1'b0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done   <= 1'b1;
                    m_result <= m_pending;
                end
            end
        end else if (req && !flush) begin
            m_op      <= ALUControl;
            m_a       <= Op1;
            m_b       <= Op2;
            m_pending <= ref_m(ALUControl, Op1, Op2);
            m_busy    <= 1'b1;
            if (is_special(ALUControl, Op1, Op2)) begin
                m_done   <= 1'b1;
                m_result <= ref_m(ALUControl, Op1, Op2);
            end else begin
                m_left   <= 33;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("busy",   {31'd0, busy},  {31'd0, m_busy});
            check("done",   {31'd0, done},  {31'd0, m_done});
            check("Stall",  {31'd0, Stall}, {31'd0, req & ~m_done});
            check("Result", Result, m_result);
            if (m_done)
                $display("[TB] txn op=%h a=%h b=%h result=%h", m_op, m_a, m_b, m_result);
        end
    endtask

    // Drive one request; lat = cycles from accept edge to the DUT done cycle (-1 if none).
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input bit drop, input bit block_first,
                          output int lat, output logic [31:0] res);
        int cyc;
        bit fin;
        lat = -1;
        res = 32'd0;
        @(negedge clk); #2;
        req = 1'b1; ALUControl = op; Op1 = a; Op2 = b; flush = block_first;
        if (block_first) begin
            @(negedge clk); #2;
            flush = 1'b0;
        end
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk); #2;
            cyc++;
            if (done && lat < 0) begin
                lat = cyc;
                res = Result;
            end
            if (m_done || !m_busy) begin
                fin = 1'b1;
                if (!m_done)
                    $display("[TB] txn op=%h a=%h b=%h flushed at cycle %0d", op, a, b, cyc);
            end else if (cyc >= 60) begin
                tests++;
                fails++;
                $display("[TB] FAIL timeout: op=%h no completion after %0d cycles", op, cyc);
                fin = 1'b1;
            end else begin
                Op1 = $urandom;
                Op2 = $urandom;
                ALUControl = 6'($urandom);
                if (drop) req = 1'b0;
                flush = (cyc == flush_at);
            end
        end
        req = 1'b0;
        flush = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return MIN_INT;
            3: return 32'($urandom_range(0, 15));
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [31:0] lat;
    } vec_t;

    vec_t       vecs [12];
    logic [5:0] ops  [8];

    initial begin
        int          lat;
        logic [31:0] res;

        vecs[0]  = '{ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32'd34};
        vecs[1]  = '{ALU_MULH,   MIN_INT,      MIN_INT,      32'h40000000, 32'd34};
        vecs[2]  = '{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd34};
        vecs[3]  = '{ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd34};
        vecs[4]  = '{ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'd34};
        vecs[5]  = '{ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'd34};
        vecs[6]  = '{ALU_DIV,    32'h00001234, 32'd0,        32'hFFFFFFFF, 32'd1};
        vecs[7]  = '{ALU_REMU,   32'd5,        32'd0,        32'd5,        32'd1};
        vecs[8]  = '{ALU_DIV,    MIN_INT,      32'hFFFFFFFF, MIN_INT,      32'd1};
        vecs[9]  = '{ALU_REM,    MIN_INT,      32'hFFFFFFFF, 32'd0,        32'd1};
        vecs[10] = '{ALU_NOP,    32'd5,        32'd6,        32'd0,        32'd1};
        vecs[11] = '{ALU_DIVU,   32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'd34};
        ops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

        rst = 1'b1; req = 1'b0; flush = 1'b0; ALUControl = 6'd0; Op1 = 32'd0; Op2 = 32'd0;
        fork
            compare_loop();
        join_none
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Pin the reference model to hand-computed values.
        for (int i = 0; i < 12; i++)
            check("model vector", ref_m(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);

        // Directed vectors through the DUT, including latency.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, 1'b0, 1'b0, lat, res);
            check("directed latency", lat, vecs[i].lat);
            check("directed result", res, vecs[i].exp);
        end

        // Flush in CALC cycle 10: no done, Result keeps DIVU result, busy drops.
        run_op(ALU_MUL, 32'h00012345, 32'h00000777, 10, 1'b0, 1'b0, lat, res);
        check("flush no done", lat, 32'hFFFFFFFF);
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush keeps Result", Result, 32'h0FFFFFFF);

        // Next request after a flush is accepted normally.
        run_op(ALU_MUL, 32'd7, 32'hFFFFFFFD, -1, 1'b0, 1'b0, lat, res);
        check("post-flush latency", lat, 32'd34);
        check("post-flush result", res, 32'hFFFFFFEB);

        // flush together with req in IDLE blocks acceptance for that cycle.
        run_op(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, 1'b1, lat, res);
        check("idle-flush latency", lat, 32'd34);
        check("idle-flush result", res, 32'hFFFFFFFE);

        // Dropping req mid-operation does not abort.
        run_op(ALU_REM, 32'hFFFFFFF9, 32'd2, -1, 1'b1, 1'b0, lat, res);
        check("drop-req latency", lat, 32'd34);
        check("drop-req result", res, 32'hFFFFFFFF);

        // Asynchronous reset in the middle of a CALC cycle.
        @(negedge clk); #2;
        req = 1'b1; ALUControl = ALU_MULHU; Op1 = 32'hFFFFFFFF; Op2 = 32'd3;
        repeat (6) begin
            @(negedge clk); #2;
        end
        check("busy before rst", {31'd0, busy}, 32'd1);
        check("Result before rst", Result, 32'hFFFFFFFF);
        rst = 1'b1;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst Result", Result, 32'd0);
        req = 1'b0;
        @(negedge clk); #2;
        rst = 1'b0;

        // Randomised operations.
        for (int n = 0; n < 1200; n++) begin
            int          r, fa;
            bit          dr, bf, sp;
            logic [5:0]  op;
            logic [31:0] a, b;
            r = $urandom_range(0, 19);
            if (r < 16)      op = ops[r % 8];
            else if (r < 18) op = ALU_NOP;
            else             op = 6'($urandom);
            a  = pick();
            b  = pick();
            fa = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 33) : -1;
            dr = ($urandom_range(0, 7) == 0);
            bf = ($urandom_range(0, 9) == 0);
            sp = is_special(op, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(op, a, b, fa, dr, bf, lat, res);
            if (fa < 0 || sp)
                check("random latency", lat, sp ? 32'd1 : 32'd34);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
